trg_in_rx: RTL and testbench

- Front-end (FEE) side receiver for one active-low trigger line driven by the trigger board (ACD, CsI track, Si, CAL FEE channels).
- Detects and validates the trigger pulse, then decodes the trigger-ID check frame that follows it.
- Keeps a local trigger counter and compares it with the received ID.
- Returns a busy level to the trigger board. One instance per trigger line.

---
 rtl/trg_pkg.sv | 23 ++
 rtl/trg_sync_edge.sv | 40 ++++
 rtl/trg_in_rx.sv | 188 ++++++++++++++++++
 tb/tb_trg_in_rx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pkg.sv
// Shared definitions for the FEE-side trigger receivers: receiver FSM states,
// default pulse timing and the check-frame sample point.
package trg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRG_MEAS,
        ST_WAIT_CHK,
        ST_CHK_SLOT,
        ST_GAP_ERR
    } trg_state_t;

    localparam int TRG_PULSE_WIDTH_DEF = 20;
    localparam int CHK_PULSE_WIDTH_DEF = 50;
    localparam int ID_WIDTH_DEF        = 12;
    localparam int CHK_SAMPLE_DEF      = CHK_PULSE_WIDTH_DEF / 2;

    // Sample point inside a check-frame slot: the middle of the slot.
    function automatic int chk_sample(input int slot_width);
        return slot_width / 2;
    endfunction

endpackage

// File: rtl/trg_sync_edge.sv
// Two-flop synchronizer for an idle-high asynchronous line, followed by a
// registered edge detector. o_rise/o_fall are aligned with o_sync: they are
// high in the first cycle o_sync shows the new level.
module trg_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;
    logic r_rise;
    logic r_fall;

    // Synchronize the line (idle high out of reset) and flag level changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
            r_rise <= r_sync & ~r_dly;
            r_fall <= ~r_sync & r_dly;
        end
    end

    assign o_sync = r_dly;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/trg_in_rx.sv
// FEE-side trigger line receiver: validates the low trigger pulse width,
// decodes the trigger-ID check frame that follows, tracks a local trigger
// counter against the received ID and returns a busy level.
module trg_in_rx
    import trg_pkg::*;
#(
    parameter int TRG_PULSE_WIDTH = TRG_PULSE_WIDTH_DEF,
    parameter int CHK_PULSE_WIDTH = CHK_PULSE_WIDTH_DEF,
    parameter int WIDTH_TOL       = 2,
    parameter int ID_WIDTH        = ID_WIDTH_DEF,
    parameter int GAP_MAX         = 200
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                trg_in_N,
    input  logic                fee_busy_in,
    input  logic                clr_cnt_in,
    output logic                trg_pulse_out,
    output logic [ID_WIDTH-1:0] trg_id_out,
    output logic                trg_id_vld_out,
    output logic                trg_id_err_out,
    output logic                frame_err_out,
    output logic [ID_WIDTH-1:0] local_cnt_out,
    output logic                busy_out
);

    // One shared cycle counter serves as width, gap, slot and high-run counter.
    localparam int CNT_W = 16;
    localparam int K_W   = $clog2(ID_WIDTH + 2);

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_W_MIN     = CNT_W'(TRG_PULSE_WIDTH - WIDTH_TOL);
    localparam logic [CNT_W-1:0] C_W_MAX     = CNT_W'(TRG_PULSE_WIDTH + WIDTH_TOL);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_MAX - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(CHK_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_SAMPLE    = CNT_W'(chk_sample(CHK_PULSE_WIDTH));
    localparam logic [K_W-1:0]   K_STOP      = K_W'(ID_WIDTH + 1);

    logic w_s_trg;
    logic w_rise;
    logic w_fall;

    trg_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [K_W-1:0]      r_k;
    logic [ID_WIDTH-1:0] r_shift;
    logic [ID_WIDTH-1:0] r_local_cnt;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_trg_pulse;
    logic                r_id_vld;
    logic                r_id_err;
    logic                r_frame_err;
    logic                r_busy;

    trg_sync_edge u_sync (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_async (trg_in_N),
        .o_sync  (w_s_trg),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Receiver FSM with registered strobes, ID decode and local counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_shift     <= '0;
            r_local_cnt <= '0;
            r_id        <= '0;
            r_trg_pulse <= 1'b0;
            r_id_vld    <= 1'b0;
            r_id_err    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_trg_pulse <= 1'b0;
            r_id_vld    <= 1'b0;
            r_id_err    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= (r_state != ST_IDLE) | fee_busy_in;

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_TRG_MEAS;
                        r_cnt   <= C_ONE;
                    end
                end

                ST_TRG_MEAS: begin
                    if (w_rise) begin
                        if (r_cnt < C_W_MIN) begin
                            // Too short: treated as a glitch, silently dropped.
                            r_state <= ST_IDLE;
                        end else begin
                            r_trg_pulse <= 1'b1;
                            r_local_cnt <= r_local_cnt + 1'b1;
                            r_state     <= ST_WAIT_CHK;
                            r_cnt       <= '0;
                        end
                    end else if (r_cnt == C_W_MAX) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_GAP_ERR;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_CHK: begin
                    if (w_fall) begin
                        r_state <= ST_CHK_SLOT;
                        r_k     <= '0;
                        r_cnt   <= C_ONE;
                    end else if (r_cnt == C_GAP_LAST) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_CHK_SLOT: begin
                    // Slot timing first; an error below overrides the counter.
                    if (r_cnt == C_SLOT_LAST) begin
                        r_cnt <= '0;
                        r_k   <= r_k + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == C_SAMPLE) begin
                        if (r_k == '0) begin
                            if (w_s_trg) begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_GAP_ERR;
                                r_cnt       <= '0;
                            end
                        end else if (r_k == K_STOP) begin
                            if (!w_s_trg) begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_GAP_ERR;
                                r_cnt       <= '0;
                            end else begin
                                r_id        <= r_shift;
                                r_id_vld    <= 1'b1;
                                r_id_err    <= (r_shift != r_local_cnt);
                                r_local_cnt <= r_shift;
                                r_state     <= ST_IDLE;
                            end
                        end else begin
                            // Data slot, MSB first, low line means 1.
                            r_shift <= {r_shift[ID_WIDTH-2:0], ~w_s_trg};
                        end
                    end
                end

                ST_GAP_ERR: begin
                    if (!w_s_trg) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_SLOT_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // Clear wins over any increment or resync in the same cycle.
            if (clr_cnt_in) begin
                r_local_cnt <= '0;
            end
        end
    end

    assign trg_pulse_out  = r_trg_pulse;
    assign trg_id_out     = r_id;
    assign trg_id_vld_out = r_id_vld;
    assign trg_id_err_out = r_id_err;
    assign frame_err_out  = r_frame_err;
    assign local_cnt_out  = r_local_cnt;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_trg_in_rx.sv
// Testbench for trg_in_rx: scenario tasks drive the trigger line; decoded
// IDs are checked against a queue of expected results filled as frames are sent.
module tb_trg_in_rx;

    localparam int IDW = 12;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           trg_in_N;
    logic           fee_busy_in;
    logic           clr_cnt_in;
    logic           trg_pulse_out;
    logic [IDW-1:0] trg_id_out;
    logic           trg_id_vld_out;
    logic           trg_id_err_out;
    logic           frame_err_out;
    logic [IDW-1:0] local_cnt_out;
    logic           busy_out;

    trg_in_rx dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .trg_in_N       (trg_in_N),
        .fee_busy_in    (fee_busy_in),
        .clr_cnt_in     (clr_cnt_in),
        .trg_pulse_out  (trg_pulse_out),
        .trg_id_out     (trg_id_out),
        .trg_id_vld_out (trg_id_vld_out),
        .trg_id_err_out (trg_id_err_out),
        .frame_err_out  (frame_err_out),
        .local_cnt_out  (local_cnt_out),
        .busy_out       (busy_out)
    );

    always #10 clk_in = ~clk_in;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
    } exp_t;

    exp_t           exp_q[$];
    logic [IDW-1:0] m_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_ferr = 0;
    int n_vld = 0;
    int last_pulse_cyc = 0;
    int last_ferr_cyc = 0;

    // Output monitor: counts strobes and scores every decoded ID.
    always @(negedge clk_in) begin
        exp_t e;
        cyc++;
        if (rst_n_in) begin
            if (trg_pulse_out) begin
                n_pulse++;
                last_pulse_cyc = cyc;
            end
            if (frame_err_out) begin
                n_ferr++;
                last_ferr_cyc = cyc;
            end
            if (trg_id_vld_out) begin
                n_vld++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vld id=%h (no frame pending)", trg_id_out);
                end else begin
                    e = exp_q.pop_front();
                    if (trg_id_out !== e.id) begin
                        errors++;
                        $display("FAIL sb_id got %h want %h", trg_id_out, e.id);
                    end
                    checks++;
                    if (trg_id_err_out !== e.err) begin
                        errors++;
                        $display("FAIL sb_id_err got %b want %b (id %h)", trg_id_err_out, e.err, e.id);
                    end
                end
            end else if (trg_id_err_out) begin
                checks++;
                errors++;
                $display("FAIL id_err_without_vld got 1 want 0");
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_trig(input int n);
        @(negedge clk_in);
        trg_in_N = 1'b0;
        repeat (n) @(negedge clk_in);
        trg_in_N = 1'b1;
        if (n >= 18 && n <= 22) m_cnt = m_cnt + 1'b1;
    endtask

    // Start slot, 12 data slots, then either a normal (high) stop or a bad low stop.
    task automatic send_frame(input logic [IDW-1:0] id, input bit bad_stop);
        exp_t e;
        @(negedge clk_in);
        trg_in_N = 1'b0;
        repeat (50) @(negedge clk_in);
        for (int i = IDW - 1; i >= 0; i--) begin
            trg_in_N = ~id[i];
            repeat (50) @(negedge clk_in);
        end
        if (bad_stop) begin
            trg_in_N = 1'b0;
            repeat (50) @(negedge clk_in);
        end
        trg_in_N = 1'b1;
        if (!bad_stop) begin
            e.id  = id;
            e.err = (id != m_cnt);
            exp_q.push_back(e);
            m_cnt = id;
        end
    endtask

    task automatic wait_vld(output bit ok);
        int t;
        t = 0;
        while (trg_id_vld_out !== 1'b1 && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        ok = (t < 100);
    endtask

    task automatic test_reset;
        rst_n_in    = 1'b0;
        trg_in_N    = 1'b1;
        fee_busy_in = 1'b0;
        clr_cnt_in  = 1'b0;
        m_cnt       = '0;
        idle(3);
        checks++;
        if (trg_pulse_out !== 1'b0) begin errors++; $display("FAIL rst_trg_pulse got %b want 0", trg_pulse_out); end
        checks++;
        if (trg_id_out !== '0) begin errors++; $display("FAIL rst_trg_id got %h want 000", trg_id_out); end
        checks++;
        if ({trg_id_vld_out, trg_id_err_out, frame_err_out} !== 3'b000) begin
            errors++; $display("FAIL rst_strobes got %b want 000", {trg_id_vld_out, trg_id_err_out, frame_err_out});
        end
        checks++;
        if (local_cnt_out !== '0) begin errors++; $display("FAIL rst_local_cnt got %h want 000", local_cnt_out); end
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_out); end
        rst_n_in = 1'b1;
        idle(5);
        checks++;
        if ({busy_out, local_cnt_out, trg_pulse_out} !== '0) begin
            errors++; $display("FAIL post_rst_idle got busy=%b cnt=%h pulse=%b want 0", busy_out, local_cnt_out, trg_pulse_out);
        end
    endtask

    task automatic test_basic;
        int p0, f0, v0;
        bit ok;
        p0 = n_pulse; f0 = n_ferr; v0 = n_vld;
        send_trig(20);
        idle(6);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy_gap got %b want 1", busy_out); end
        checks++;
        if (local_cnt_out !== 12'h001) begin errors++; $display("FAIL basic_cnt_after_trig got %h want 001", local_cnt_out); end
        idle(10);
        send_frame(12'h001, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_vld_timeout got none want vld"); end
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy_at_vld got %b want 1", busy_out); end
        idle(1);
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_busy_after_vld got %b want 0", busy_out); end
        idle(5);
        checks++;
        if (n_pulse - p0 != 1) begin errors++; $display("FAIL basic_pulse_count got %0d want 1", n_pulse - p0); end
        checks++;
        if (n_ferr - f0 != 0 || n_vld - v0 != 1) begin
            errors++; $display("FAIL basic_strobes got ferr=%0d vld=%0d want 0/1", n_ferr - f0, n_vld - v0);
        end
        checks++;
        if (local_cnt_out !== 12'h001) begin errors++; $display("FAIL basic_cnt got %h want 001", local_cnt_out); end
    endtask

    task automatic test_width;
        int p0, f0;
        bit ok;
        p0 = n_pulse; f0 = n_ferr;
        send_trig(17);
        idle(30);
        checks++;
        if (n_pulse != p0 || n_ferr != f0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL width17 got pulse=%0d ferr=%0d busy=%b want 0/0/0", n_pulse - p0, n_ferr - f0, busy_out);
        end
        send_trig(23);
        idle(5);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL width23_busy got %b want 1", busy_out); end
        checks++;
        if (n_ferr - f0 != 1 || n_pulse != p0) begin
            errors++; $display("FAIL width23 got ferr=%0d pulse=%0d want 1/0", n_ferr - f0, n_pulse - p0);
        end
        idle(60);
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL width23_recover got %b want 0", busy_out); end
        checks++;
        if (local_cnt_out !== m_cnt) begin errors++; $display("FAIL width_cnt got %h want %h", local_cnt_out, m_cnt); end
        send_trig(18);
        idle(10);
        send_frame(m_cnt, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL width18_vld_timeout got none want vld"); end
        idle(30);
        send_trig(22);
        idle(10);
        send_frame(m_cnt, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL width22_vld_timeout got none want vld"); end
        idle(30);
        checks++;
        if (n_pulse - p0 != 2 || n_ferr - f0 != 1) begin
            errors++; $display("FAIL width_edges got pulse=%0d ferr=%0d want 2/1", n_pulse - p0, n_ferr - f0);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        send_trig(20);
        idle(10);
        send_frame(12'hFFF, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_load_timeout got none want vld"); end
        idle(30);
        checks++;
        if (local_cnt_out !== 12'hFFF) begin errors++; $display("FAIL wrap_resync got %h want fff", local_cnt_out); end
        send_trig(20);
        idle(6);
        checks++;
        if (local_cnt_out !== 12'h000) begin errors++; $display("FAIL wrap_cnt got %h want 000", local_cnt_out); end
        idle(4);
        send_frame(12'h000, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok || trg_id_err_out !== 1'b0) begin
            errors++; $display("FAIL wrap_vld got ok=%b err=%b want 1/0", ok, trg_id_err_out);
        end
        idle(30);
    endtask

    task automatic test_id_err;
        bit ok;
        @(negedge clk_in);
        clr_cnt_in = 1'b1;
        @(negedge clk_in);
        clr_cnt_in = 1'b0;
        m_cnt = '0;
        checks++;
        if (local_cnt_out !== 12'h000) begin errors++; $display("FAIL clr_cnt got %h want 000", local_cnt_out); end
        send_trig(20);
        idle(10);
        send_frame(12'h001, 1'b0);
        wait_vld(ok);
        idle(30);
        send_trig(20);
        idle(10);
        send_frame(12'h800, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok || trg_id_err_out !== 1'b1) begin
            errors++; $display("FAIL id_err got ok=%b err=%b want 1/1", ok, trg_id_err_out);
        end
        idle(5);
        checks++;
        if (local_cnt_out !== 12'h800) begin errors++; $display("FAIL id_err_resync got %h want 800", local_cnt_out); end
        idle(25);
    endtask

    task automatic test_gap_timeout;
        int f0, v0;
        f0 = n_ferr; v0 = n_vld;
        send_trig(20);
        idle(250);
        checks++;
        if (n_ferr - f0 != 1 || n_vld != v0) begin
            errors++; $display("FAIL gap_strobes got ferr=%0d vld=%0d want 1/0", n_ferr - f0, n_vld - v0);
        end
        checks++;
        if (last_ferr_cyc - last_pulse_cyc != 200) begin
            errors++; $display("FAIL gap_timing got %0d want 200", last_ferr_cyc - last_pulse_cyc);
        end
        checks++;
        if (busy_out !== 1'b0 || local_cnt_out !== m_cnt) begin
            errors++; $display("FAIL gap_idle got busy=%b cnt=%h want 0/%h", busy_out, local_cnt_out, m_cnt);
        end
    endtask

    task automatic test_bad_stop;
        int f0, v0;
        f0 = n_ferr; v0 = n_vld;
        send_trig(20);
        idle(10);
        send_frame(12'h0A5, 1'b1);
        idle(20);
        checks++;
        if (busy_out !== 1'b1 || n_ferr - f0 != 1) begin
            errors++; $display("FAIL bad_stop got busy=%b ferr=%0d want 1/1", busy_out, n_ferr - f0);
        end
        idle(45);
        checks++;
        if (busy_out !== 1'b0 || n_vld != v0) begin
            errors++; $display("FAIL bad_stop_recover got busy=%b vld=%0d want 0/0", busy_out, n_vld - v0);
        end
        checks++;
        if (local_cnt_out !== m_cnt) begin errors++; $display("FAIL bad_stop_cnt got %h want %h", local_cnt_out, m_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [IDW-1:0] id;
        bit ok;
        id = 12'h3C3;
        send_trig(20);
        idle(10);
        @(negedge clk_in);
        trg_in_N = 1'b0;
        repeat (50) @(negedge clk_in);
        for (int k = 1; k <= 6; k++) begin
            trg_in_N = ~id[IDW - k];
            repeat ((k == 6) ? 25 : 50) @(negedge clk_in);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({trg_pulse_out, trg_id_out, trg_id_vld_out, trg_id_err_out, frame_err_out, local_cnt_out, busy_out} !== '0) begin
            errors++; $display("FAIL mid_reset_async got cnt=%h id=%h busy=%b want all 0", local_cnt_out, trg_id_out, busy_out);
        end
        trg_in_N = 1'b1;
        idle(3);
        rst_n_in = 1'b1;
        m_cnt = '0;
        idle(10);
        checks++;
        if (local_cnt_out !== '0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL mid_reset_release got cnt=%h busy=%b want 000/0", local_cnt_out, busy_out);
        end
        send_trig(20);
        idle(10);
        send_frame(12'h001, 1'b0);
        wait_vld(ok);
        checks++;
        if (!ok || trg_id_out !== 12'h001) begin
            errors++; $display("FAIL mid_reset_redecode got ok=%b id=%h want 1/001", ok, trg_id_out);
        end
        idle(30);
        checks++;
        if (local_cnt_out !== 12'h001) begin errors++; $display("FAIL mid_reset_cnt got %h want 001", local_cnt_out); end
    endtask

    task automatic test_fee_busy;
        @(negedge clk_in);
        fee_busy_in = 1'b1;
        #1;
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL fee_busy_early got %b want 0", busy_out); end
        @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL fee_busy got %b want 1", busy_out); end
        fee_busy_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL fee_busy_release got %b want 0", busy_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_width();
        test_wrap();
        test_id_err();
        test_gap_timeout();
        test_bad_stop();
        test_reset_mid();
        test_fee_busy();
        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
